rain_pulse_generator: RTL and testbench

//  Tipping-bucket emulator: the transmit end of the nRain interface. Converts a

---
 rtl/rain_pulse_generator.sv | 160 ++++++++++++++++
 tb/tb_rain_pulse_generator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rain_pulse_generator.sv
// Tipping-bucket emulator: turns a ddd.dd mm BCD target into floor(target/0.28 mm)
// active-low nRain pulses, spaced so the receiving gauge's debounce always clears.
module rain_pulse_generator #(
    parameter int PULSE_LOW_CYCLES = 164,
    parameter int PULSE_GAP_CYCLES = 1640,
    parameter int UNITS_PER_PULSE  = 28
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  tgt_hundreds_bcd,
    input  logic [3:0]  tgt_tens_bcd,
    input  logic [3:0]  tgt_units_bcd,
    input  logic [3:0]  tgt_tenths_bcd,
    input  logic [3:0]  tgt_hundredths_bcd,
    output logic        nRain,
    output logic        busy,
    output logic        done,
    output logic        bcd_error,
    output logic [15:0] pulse_target,
    output logic [15:0] pulses_sent,
    output logic [2:0]  dbg_state
);

    localparam int TMAX = (PULSE_LOW_CYCLES > PULSE_GAP_CYCLES) ? PULSE_LOW_CYCLES : PULSE_GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [16:0]   UPP      = 17'(UNITS_PER_PULSE);
    localparam logic [TW-1:0] LOW_LOAD = TW'(PULSE_LOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(PULSE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_LOW  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [16:0]   rem_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   target_q;
    logic [15:0]   sent_q;
    logic          nrain_q;
    logic          busy_q;
    logic          done_q;
    logic          bcd_error_q;

    logic          digits_ok;
    logic [16:0]   value;

    assign digits_ok = (tgt_hundreds_bcd <= 4'd9) && (tgt_tens_bcd <= 4'd9) &&
                       (tgt_units_bcd <= 4'd9) && (tgt_tenths_bcd <= 4'd9) &&
                       (tgt_hundredths_bcd <= 4'd9);

    assign value = ({13'd0, tgt_hundreds_bcd} * 17'd10000) +
                   ({13'd0, tgt_tens_bcd}     * 17'd1000) +
                   ({13'd0, tgt_units_bcd}    * 17'd100) +
                   ({13'd0, tgt_tenths_bcd}   * 17'd10) +
                    {13'd0, tgt_hundredths_bcd};

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            timer_q     <= '0;
            target_q    <= '0;
            sent_q      <= '0;
            nrain_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_error_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            bcd_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (digits_ok) begin
                            rem_q    <= value;
                            target_q <= '0;
                            sent_q   <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_CALC;
                        end else begin
                            bcd_error_q <= 1'b1;
                        end
                    end
                end
                // Repeated subtraction: one pulse counted per cycle, remainder dropped.
                S_CALC: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rem_q >= UPP) begin
                        rem_q    <= rem_q - UPP;
                        target_q <= target_q + 16'd1;
                    end else if (target_q != 16'd0) begin
                        state_q <= S_LOW;
                        nrain_q <= 1'b0;
                        sent_q  <= sent_q + 16'd1;
                        timer_q <= LOW_LOAD;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        nrain_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (timer_q == '0) begin
                        state_q <= S_GAP;
                        nrain_q <= 1'b1;
                        timer_q <= GAP_LOAD;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (sent_q < target_q) begin
                        state_q <= S_LOW;
                        nrain_q <= 1'b0;
                        sent_q  <= sent_q + 16'd1;
                        timer_q <= LOW_LOAD;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    nrain_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nRain        = nrain_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bcd_error    = bcd_error_q;
    assign pulse_target = target_q;
    assign pulses_sent  = sent_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rain_pulse_generator.sv
// Bench for rain_pulse_generator: randomized and directed targets, a timeline
// model of busy/nRain, and a scoreboard of expected done / bcd_error strobes.
module tb_rain_pulse_generator;
  localparam int LOW = 3;
  localparam int GAP = 5;
  localparam int PER = LOW + GAP;
  localparam int UPP = 28;
  localparam int W   = 64;
  localparam int NEVER = 32'h3fff_ffff;

  logic        Clock = 1'b0;
  logic        nReset, start, abort;
  logic [3:0]  h_d, t_d, u_d, d_d, c_d;
  logic        nRain, busy, done, bcd_error;
  logic [15:0] pulse_target, pulses_sent;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;

  // reference timeline of the current run
  bit run_active = 0;
  int run_c = 0;
  int run_n = 0;
  int run_abort = NEVER;
  int last_target = 0;
  int last_sent = 0;

  logic [W-1:0] exp_q[$];

  rain_pulse_generator #(
    .PULSE_LOW_CYCLES(LOW),
    .PULSE_GAP_CYCLES(GAP),
    .UNITS_PER_PULSE(UPP)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .start(start),
    .abort(abort),
    .tgt_hundreds_bcd(h_d),
    .tgt_tens_bcd(t_d),
    .tgt_units_bcd(u_d),
    .tgt_tenths_bcd(d_d),
    .tgt_hundredths_bcd(c_d),
    .nRain(nRain),
    .busy(busy),
    .done(done),
    .bcd_error(bcd_error),
    .pulse_target(pulse_target),
    .pulses_sent(pulses_sent),
    .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input int kind, input int tgt, input int snt, input int cy);
    return {kind[1:0], tgt[15:0], snt[15:0], cy[29:0]};
  endfunction

  // a run: CALC for N+1 cycles, then N pulses of PER cycles, then the done cycle
  function automatic logic exp_busy(input int t);
    if (!run_active || t > run_abort) return 1'b0;
    return (t >= run_c + 1) && (t < run_c + 2 + run_n + run_n * PER);
  endfunction

  function automatic logic exp_nrain(input int t);
    int p0;
    p0 = run_c + 2 + run_n;
    if (!run_active || t > run_abort) return 1'b1;
    if (t >= p0 && t < p0 + run_n * PER && ((t - p0) % PER) < LOW) return 1'b0;
    return 1'b1;
  endfunction

  // monitor / scoreboard
  always @(negedge Clock) begin
    if (mon_en) begin
      logic [W-1:0] e;
      chk("busy", busy, exp_busy(cyc));
      chk("nRain", nRain, exp_nrain(cyc));
      if (done || bcd_error) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe done=%0b bcd_error=%0b cyc=%0d", done, bcd_error, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", bcd_error ? 1 : 0, e[63:62]);
          chk("strobe_pulse_target", pulse_target, e[61:46]);
          chk("strobe_pulses_sent", pulses_sent, e[45:30]);
          chk("strobe_cycle", cyc, e[29:0]);
        end
      end
    end
  end

  task automatic set_digits(input int v);
    h_d = 4'((v / 10000) % 10);
    t_d = 4'((v / 1000) % 10);
    u_d = 4'((v / 100) % 10);
    d_d = 4'((v / 10) % 10);
    c_d = 4'(v % 10);
  endtask

  // driver: one run from IDLE, optionally aborted abort_off cycles into the pulse train
  task automatic do_run(input int v, input int abort_off, input bit start_busy, input bit abort_with_start);
    int c0, n, a, k;
    @(negedge Clock);
    set_digits(v);
    start = 1'b1;
    abort = abort_with_start;
    c0 = cyc;
    n = v / UPP;
    run_c = c0;
    run_n = n;
    run_abort = NEVER;
    run_active = 1;
    exp_q.push_back(pack(0, n, n, c0 + 2 + n + n * PER));
    @(negedge Clock);
    start = 1'b0;
    abort = 1'b0;
    if (abort_off >= 0 && n >= 1) begin
      while (cyc < c0 + 2 + n + abort_off) @(negedge Clock);
      abort = 1'b1;
      a = cyc;
      run_abort = a;
      void'(exp_q.pop_back());
      @(negedge Clock);
      abort = 1'b0;
      k = abort_off / PER + 1;
      if (k > n) k = n;
      chk("abort_busy", busy, 0);
      chk("abort_nRain", nRain, 1);
      chk("abort_pulses_sent", pulses_sent, k);
      chk("abort_pulse_target", pulse_target, n);
      last_target = n;
      last_sent = k;
    end else begin
      if (start_busy && n >= 1) begin
        while (cyc < c0 + 3) @(negedge Clock);
        set_digits(99999);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
      end
      while (cyc < c0 + 3 + n + n * PER) @(negedge Clock);
      last_target = n;
      last_sent = n;
    end
  endtask

  task automatic bcd_err_run();
    int c0;
    @(negedge Clock);
    set_digits($urandom_range(0, 99999));
    t_d = 4'hA;
    start = 1'b1;
    c0 = cyc;
    exp_q.push_back(pack(1, last_target, last_sent, c0 + 1));
    @(negedge Clock);
    start = 1'b0;
    t_d = 4'h0;
    repeat (3) @(negedge Clock);
    chk("bcd_target_kept", pulse_target, last_target);
    chk("bcd_sent_kept", pulses_sent, last_sent);
  endtask

  task automatic idle_abort();
    @(negedge Clock);
    abort = 1'b1;
    repeat (3) @(negedge Clock);
    abort = 1'b0;
    chk("idle_abort_target", pulse_target, last_target);
    chk("idle_abort_sent", pulses_sent, last_sent);
  endtask

  task automatic reset_in_low();
    int c0;
    @(negedge Clock);
    set_digits(100);
    start = 1'b1;
    c0 = cyc;
    run_c = c0;
    run_n = 3;
    run_abort = NEVER;
    run_active = 1;
    exp_q.push_back(pack(0, 3, 3, c0 + 2 + 3 + 3 * PER));
    @(negedge Clock);
    start = 1'b0;
    while (cyc < c0 + 2 + 3 + 1) @(negedge Clock);
    chk("pre_reset_nRain", nRain, 0);
    #2;
    nReset = 1'b0;
    run_active = 0;
    void'(exp_q.pop_back());
    #1;
    chk("rst_nRain", nRain, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_target", pulse_target, 0);
    chk("rst_sent", pulses_sent, 0);
    last_target = 0;
    last_sent = 0;
    @(negedge Clock);
    #1 nReset = 1'b1;
  endtask

  initial begin
    int v, n, ao;
    nReset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_digits(0);
    #2 nReset = 1'b0;
    #1;
    chk("reset_nRain", nRain, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bcd_error", bcd_error, 0);
    chk("reset_target", pulse_target, 0);
    chk("reset_sent", pulses_sent, 0);
    repeat (2) @(negedge Clock);
    #1 nReset = 1'b1;
    mon_en = 1;

    do_run(28, -1, 0, 0);
    do_run(100, -1, 1, 0);
    do_run(27, -1, 0, 0);
    do_run(0, -1, 0, 0);
    do_run(100, 9, 0, 0);
    do_run(100, -1, 0, 0);
    bcd_err_run();
    idle_abort();
    do_run(56, -1, 0, 1);
    reset_in_low();
    do_run(84, -1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      v = $urandom_range(0, 320);
      n = v / UPP;
      ao = -1;
      if (n >= 1 && $urandom_range(0, 2) == 0) ao = $urandom_range(0, n * PER - 1);
      do_run(v, ao, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    do_run(99999, -1, 0, 0);
    repeat (5) @(negedge Clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
